// File: rtl/srl_seq_pkg.sv
// Shared constants and helpers for the SRL chain sequencer.
package srl_seq_pkg;

    // FSM encoding kept as plain constants so legacy code can compare raw values.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_FILL = 2'd1;
    localparam state_t ST_RUN  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    // Taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10).
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // One Fibonacci step: shift left, feedback is the parity of the tapped bits.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/srl_seq_lfsr.sv
// 16-bit pseudo-random source for the shift data and the RUN-state shift enable.
module srl_seq_lfsr
    import srl_seq_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic data_bit,
    output logic ce_bit
);

    // An all-zero state would lock the LFSR, so a zero seed is replaced.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] lfsr_reg;

    // Advance only while enabled; reset reloads the seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr_reg <= SEED_EFF;
        else if (en)
            lfsr_reg <= lfsr_step(lfsr_reg);
    end

    assign data_bit = lfsr_reg[0];
    assign ce_bit   = lfsr_reg[8];

endmodule

// File: rtl/srl_chain_sequencer.sv
// Drives a bank of SRL lanes with pseudo-random data, mirrors their contents in a
// shadow register and flags any lane (or the MC31 cascade tap) that reads back wrong.
module srl_chain_sequencer
    import srl_seq_pkg::*;
#(
    parameter int          DEPTH      = 32,
    parameter int          LANES      = 7,
    parameter int          Q_REG      = 0,
    parameter int          ADDR_HOLD  = 4,
    parameter int          RUN_CYCLES = 1024,
    parameter logic [15:0] SEED       = DEFAULT_SEED,
    localparam int         AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  srl_d,
    output logic                  srl_ce,
    output logic [LANES*AW-1:0]   srl_a,
    input  logic [LANES-1:0]      srl_q,
    input  logic                  srl_q31,
    output logic                  busy,
    output logic                  done,
    output logic [LANES:0]        error
);

    localparam int RW = $clog2(RUN_CYCLES + 1);
    localparam int HW = $clog2(ADDR_HOLD + 1);

    state_t            state_reg, state_next;
    logic [AW-1:0]     fill_cnt_reg;
    logic [RW-1:0]     run_cnt_reg;
    logic [HW-1:0]     hold_cnt_reg;
    logic [AW-1:0]     base_reg, base_next;
    logic [DEPTH-1:0]  shadow_reg;
    logic [LANES*AW-1:0] addr_next;
    logic              lfsr_d, lfsr_ce;
    logic              start_clr;
    logic              run_stay;
    logic [LANES-1:0]  exp_lane;
    logic [LANES:0]    exp_vec, obs_vec, exp_cmp;
    logic              cmp_en;

    srl_seq_lfsr #(.SEED(SEED)) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (state_reg != ST_IDLE),
        .data_bit (lfsr_d),
        .ce_bit   (lfsr_ce)
    );

    // A start only counts when the sequencer is not already mid-pass.
    assign start_clr = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    assign run_stay  = (state_reg == ST_RUN) && (state_next == ST_RUN);

    // Next-state logic: fill the chains, run the checks, then park in DONE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_FILL;
            ST_FILL: if (fill_cnt_reg == AW'(DEPTH - 1)) state_next = ST_RUN;
            ST_RUN:  if (run_cnt_reg == RW'(RUN_CYCLES - 1)) state_next = ST_DONE;
            ST_DONE: if (start) state_next = ST_FILL;
            default: state_next = ST_IDLE;
        endcase
    end

    // Base address restarts at 0 on RUN entry and steps every ADDR_HOLD RUN cycles.
    always_comb begin
        base_next = base_reg;
        if (state_next != ST_RUN || state_reg != ST_RUN)
            base_next = '0;
        else if (hold_cnt_reg == HW'(ADDR_HOLD - 1))
            base_next = base_reg + AW'(1);
    end

    // Lane i reads (base + i); AW-bit arithmetic gives the wrap for power-of-two depths.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign addr_next[gi*AW +: AW] = base_next + AW'(gi);
        assign exp_lane[gi]           = shadow_reg[srl_a[gi*AW +: AW]];
    end

    // State register and pass counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            fill_cnt_reg <= '0;
            run_cnt_reg  <= '0;
            hold_cnt_reg <= '0;
            base_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            fill_cnt_reg <= (state_reg == ST_FILL && state_next == ST_FILL) ? fill_cnt_reg + AW'(1) : '0;
            run_cnt_reg  <= run_stay ? run_cnt_reg + RW'(1) : '0;
            if (run_stay && hold_cnt_reg != HW'(ADDR_HOLD - 1))
                hold_cnt_reg <= hold_cnt_reg + HW'(1);
            else
                hold_cnt_reg <= '0;
            base_reg     <= base_next;
        end
    end

    // Registered SRL drive, computed from the next state so it lines up with the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            srl_d  <= 1'b0;
            srl_ce <= 1'b0;
            srl_a  <= '0;
        end else begin
            srl_d  <= (state_next == ST_IDLE) ? 1'b0 : lfsr_d;
            srl_ce <= (state_next == ST_FILL) ? 1'b1 :
                      (state_next == ST_RUN)  ? lfsr_ce : 1'b0;
            srl_a  <= (state_next == ST_IDLE) ? '0 : addr_next;
        end
    end

    // Shadow shifts on exactly the edges where the lanes see srl_ce high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            shadow_reg <= '0;
        else if (srl_ce)
            shadow_reg <= {shadow_reg[DEPTH-2:0], srl_d};
    end

    assign exp_vec = {shadow_reg[DEPTH-1], exp_lane};
    assign obs_vec = {srl_q31, srl_q};

    // With registered lane outputs the readback lags a cycle, so expectation lags too.
    if (Q_REG != 0) begin : g_qreg
        logic [LANES:0] exp_d_reg;
        logic           en_d_reg;

        // One-cycle delay of expected values and compare enable.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                exp_d_reg <= '0;
                en_d_reg  <= 1'b0;
            end else begin
                exp_d_reg <= exp_vec;
                en_d_reg  <= (state_reg == ST_RUN);
            end
        end
        assign exp_cmp = exp_d_reg;
        assign cmp_en  = en_d_reg;
    end else begin : g_qcomb
        assign exp_cmp = exp_vec;
        assign cmp_en  = (state_reg == ST_RUN);
    end

    // Sticky mismatch flags; chain contents are undefined in FILL so only RUN compares.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            error <= '0;
        else if (start_clr)
            error <= '0;
        else if (cmp_en)
            error <= error | (exp_cmp ^ obs_vec);
    end

    assign busy = (state_reg == ST_FILL) || (state_reg == ST_RUN);
    assign done = (state_reg == ST_DONE);

endmodule
